// File: rtl/decode_issue_stage_pkg.sv
// Shared definitions for the decode/issue stage: widths, instruction field
// positions, opcode values and the assembly state encoding.
package decode_issue_stage_pkg;

  localparam int DATA_W = 16;
  localparam int OPC_W  = 5;
  localparam int PC_W   = 32;

  localparam int OPC_HI      = 15;
  localparam int OPC_LO      = 11;
  localparam int RD_HI       = 10;
  localparam int RD_LO       = 8;
  localparam int RS1_HI      = 7;
  localparam int RS1_LO      = 5;
  localparam int RS2_HI      = 4;
  localparam int RS2_LO      = 2;
  localparam int HAS_IMM_BIT = 1;

  localparam logic [OPC_W-1:0] OPC_NOP = 5'd0;
  localparam logic [OPC_W-1:0] OPC_ADD = 5'd1;
  localparam logic [OPC_W-1:0] OPC_SUB = 5'd2;
  localparam logic [OPC_W-1:0] OPC_AND = 5'd3;
  localparam logic [OPC_W-1:0] OPC_OR  = 5'd4;
  localparam logic [OPC_W-1:0] OPC_LD  = 5'd5;
  localparam logic [OPC_W-1:0] OPC_ST  = 5'd6;
  localparam logic [OPC_W-1:0] OPC_LDI = 5'd7;
  localparam logic [OPC_W-1:0] OPC_BEQ = 5'd8;
  localparam logic [OPC_W-1:0] OPC_JMP = 5'd9;

  typedef enum logic {
    S_OP  = 1'b0,
    S_IMM = 1'b1
  } state_e;

endpackage

// File: rtl/decode_issue_stage_if.sv
// Fetch-side handshake and ID/EX bundle of the decode/issue stage.
// master = surrounding pipeline, slave = the decode stage.
interface decode_issue_stage_if #(
  parameter int DATA_W = decode_issue_stage_pkg::DATA_W,
  parameter int OPC_W  = decode_issue_stage_pkg::OPC_W,
  parameter int PC_W   = decode_issue_stage_pkg::PC_W
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_word;
  logic [PC_W-1:0]   in_pc;
  logic              out_valid;
  logic [OPC_W-1:0]  out_opc;
  logic [2:0]        out_rd;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic [DATA_W-1:0] out_imm;
  logic [PC_W-1:0]   out_pc;

  modport master (
    output in_valid, in_word, in_pc,
    input  in_ready, out_valid, out_opc, out_rd, out_a, out_b, out_imm, out_pc
  );

  modport slave (
    input  in_valid, in_word, in_pc,
    output in_ready, out_valid, out_opc, out_rd, out_a, out_b, out_imm, out_pc
  );
endinterface

// File: rtl/decode_issue_stage_load_use_detect.sv
// Combinational load-use hazard compare of two source registers against
// the destination of a load sitting in EX.
module load_use_detect (
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [2:0] ex_rd,
  input  logic [2:0] rs1,
  input  logic [2:0] rs2,
  output logic       hazard
);
  assign hazard = ex_valid & ex_mem_read & ((ex_rd == rs1) | (ex_rd == rs2));
endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: assembles 1- or 2-word instructions, reads operands,
// inserts load-use bubbles. Optional bubble counter: DECODE_BUBBLE_STATS_EN.
module decode_issue_stage #(
  parameter int DATA_W = decode_issue_stage_pkg::DATA_W,
  parameter int OPC_W  = decode_issue_stage_pkg::OPC_W,
  parameter int PC_W   = decode_issue_stage_pkg::PC_W
) (
  input  logic              clk,
  input  logic              rst,
  decode_issue_stage_if.slave bus,
  output logic [3:0]        rd1_addr,
  output logic [2:0]        rd2_addr,
  input  logic [DATA_W-1:0] rd1_data,
  input  logic [DATA_W-1:0] rd2_data,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [2:0]        ex_rd,
  input  logic              stall,
  input  logic              flush
`ifdef DECODE_BUBBLE_STATS_EN
  ,
  output logic [15:0]       bubble_cnt
`endif
);
  import decode_issue_stage_pkg::*;

  state_e            state_q, state_d;
  logic [DATA_W-1:1] hold_word_q, hold_word_d;
  logic [PC_W-1:0]   hold_pc_q, hold_pc_d;
  logic              out_valid_q, out_valid_d;
  logic [OPC_W-1:0]  out_opc_q, out_opc_d;
  logic [2:0]        out_rd_q, out_rd_d;
  logic [DATA_W-1:0] out_a_q, out_a_d;
  logic [DATA_W-1:0] out_b_q, out_b_d;
  logic [DATA_W-1:0] out_imm_q, out_imm_d;
  logic [PC_W-1:0]   out_pc_q, out_pc_d;

  logic [DATA_W-1:1] src_word;
  logic [2:0]        rs1, rs2;
  logic              lu_hit;
  logic              hazard;
  logic              in_ready;

  // Bit 0 of a word carries no meaning, so only [15:1] is held and decoded.
  assign src_word = (state_q == S_IMM) ? hold_word_q : bus.in_word[DATA_W-1:1];
  assign rs1      = src_word[RS1_HI:RS1_LO];
  assign rs2      = src_word[RS2_HI:RS2_LO];
  assign rd1_addr = {1'b0, rs1};
  assign rd2_addr = rs2;

  load_use_detect u_load_use_detect (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .hazard      (lu_hit)
  );

  // In S_OP there is nothing to protect unless fetch is offering a word.
  assign hazard   = lu_hit & ((state_q == S_IMM) | bus.in_valid);
  assign in_ready = ~stall & ~flush & ~hazard;

  always_comb begin
    state_d     = state_q;
    hold_word_d = hold_word_q;
    hold_pc_d   = hold_pc_q;
    out_valid_d = out_valid_q;
    out_opc_d   = out_opc_q;
    out_rd_d    = out_rd_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_imm_d   = out_imm_q;
    out_pc_d    = out_pc_q;

    if (flush) begin
      state_d     = S_OP;
      out_valid_d = 1'b0;
      hold_word_d = '0;
      hold_pc_d   = '0;
    end else if (stall) begin
      state_d = state_q;
    end else if (hazard) begin
      out_valid_d = 1'b0;
    end else if (bus.in_valid) begin
      if (state_q == S_IMM) begin
        state_d     = S_OP;
        out_valid_d = 1'b1;
        out_opc_d   = src_word[OPC_HI:OPC_LO];
        out_rd_d    = src_word[RD_HI:RD_LO];
        out_a_d     = rd1_data;
        out_b_d     = rd2_data;
        out_imm_d   = bus.in_word;
        out_pc_d    = hold_pc_q;
      end else if (bus.in_word[HAS_IMM_BIT]) begin
        state_d     = S_IMM;
        out_valid_d = 1'b0;
        hold_word_d = bus.in_word[DATA_W-1:1];
        hold_pc_d   = bus.in_pc;
      end else begin
        out_valid_d = 1'b1;
        out_opc_d   = src_word[OPC_HI:OPC_LO];
        out_rd_d    = src_word[RD_HI:RD_LO];
        out_a_d     = rd1_data;
        out_b_d     = rd2_data;
        out_imm_d   = '0;
        out_pc_d    = bus.in_pc;
      end
    end else begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_OP;
      hold_word_q <= '0;
      hold_pc_q   <= '0;
      out_valid_q <= 1'b0;
      out_opc_q   <= '0;
      out_rd_q    <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_imm_q   <= '0;
      out_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      hold_word_q <= hold_word_d;
      hold_pc_q   <= hold_pc_d;
      out_valid_q <= out_valid_d;
      out_opc_q   <= out_opc_d;
      out_rd_q    <= out_rd_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_imm_q   <= out_imm_d;
      out_pc_q    <= out_pc_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_opc   = out_opc_q;
  assign bus.out_rd    = out_rd_q;
  assign bus.out_a     = out_a_q;
  assign bus.out_b     = out_b_q;
  assign bus.out_imm   = out_imm_q;
  assign bus.out_pc    = out_pc_q;

`ifdef DECODE_BUBBLE_STATS_EN
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (hazard && !stall && !flush && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_decode_issue_stage.sv
// Scoreboard bench for decode_issue_stage: directed words, expected ID/EX
// bundles queued at issue and checked by an independent monitor.
module tb_decode_issue_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_issue_stage_if bus ();

  logic [3:0]  rd1_addr;
  logic [2:0]  rd2_addr;
  logic [15:0] rd1_data, rd2_data;
  logic        ex_valid, ex_mem_read;
  logic [2:0]  ex_rd;
  logic        stall, flush;
`ifdef DECODE_BUBBLE_STATS_EN
  logic [15:0] bubble_cnt;
`endif

  logic [15:0] regs [16];
  assign rd1_data = regs[rd1_addr];
  assign rd2_data = regs[{1'b0, rd2_addr}];

  decode_issue_stage #(.DATA_W(16), .OPC_W(5), .PC_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .rd1_addr    (rd1_addr),
    .rd2_addr    (rd2_addr),
    .rd1_data    (rd1_data),
    .rd2_data    (rd2_data),
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .stall       (stall),
    .flush       (flush)
`ifdef DECODE_BUBBLE_STATS_EN
    ,
    .bubble_cnt  (bubble_cnt)
`endif
  );

  typedef struct packed {
    logic [4:0]  opc;
    logic [2:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] imm;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic expect_issue(input logic [4:0] opc, input logic [2:0] rd, input logic [15:0] a,
                              input logic [15:0] b, input logic [15:0] imm, input logic [31:0] pc);
    exp_t e;
    e.opc = opc; e.rd = rd; e.a = a; e.b = b; e.imm = imm; e.pc = pc;
    exp_q.push_back(e);
  endtask

  // A bundle is consumed by EX at the posedge following a non-stalled cycle.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && !stall) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got opc %0h pc %0h expected no bundle", bus.out_opc, bus.out_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_opc", {59'd0, bus.out_opc}, {59'd0, e.opc});
        check("out_rd",  {61'd0, bus.out_rd},  {61'd0, e.rd});
        check("out_a",   {48'd0, bus.out_a},   {48'd0, e.a});
        check("out_b",   {48'd0, bus.out_b},   {48'd0, e.b});
        check("out_imm", {48'd0, bus.out_imm}, {48'd0, e.imm});
        check("out_pc",  {32'd0, bus.out_pc},  {32'd0, e.pc});
      end
    end
  end

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  // Starts and ends one time unit after a posedge.
  task automatic issue(input logic [15:0] w, input logic [31:0] pc);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_word  = w;
    bus.in_pc    = pc;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      @(posedge clk);
    end
    #1;
    bus.in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept of word %0h expected accept", w);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd0);
    check({tag, "_opc"},   {59'd0, bus.out_opc},   64'd0);
    check({tag, "_rd"},    {61'd0, bus.out_rd},    64'd0);
    check({tag, "_a"},     {48'd0, bus.out_a},     64'd0);
    check({tag, "_b"},     {48'd0, bus.out_b},     64'd0);
    check({tag, "_imm"},   {48'd0, bus.out_imm},   64'd0);
    check({tag, "_pc"},    {32'd0, bus.out_pc},    64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 16'hA000 | 16'(i);
    regs[0] = 16'h0000;
    regs[1] = 16'h0005;
    regs[2] = 16'h0022;
    regs[3] = 16'h0033;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_word = '0; bus.in_pc = '0;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_rd = '0;
    stall = 1'b0; flush = 1'b0;
    repeat (3) to_drive();
    check_cleared("reset");
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
    to_drive();

    // Single word: opc 1, rd 2, rs1 1, rs2 1
    issue(16'h0A24, 32'd32);
    expect_issue(5'd1, 3'd2, 16'h0005, 16'h0005, 16'h0000, 32'd32);
    issue(16'h1D4C, 32'd34);
    expect_issue(5'd3, 3'd5, 16'h0022, 16'h0033, 16'h0000, 32'd34);

    // Two-word instruction
    issue(16'h0A26, 32'd100);
    @(negedge clk);
    check("imm_first_bubble", {63'd0, bus.out_valid}, 64'd0);
    to_drive();
    issue(16'h1234, 32'd102);
    expect_issue(5'd1, 3'd2, 16'h0005, 16'h0005, 16'h1234, 32'd100);

    // Reset while holding the first word of a two-word instruction
    issue(16'h0A26, 32'd200);
    rst = 1'b1;
    to_drive();
    check_cleared("rst_mid_imm");
`ifdef DECODE_BUBBLE_STATS_EN
    check("bubble_cnt_reset", {48'd0, bubble_cnt}, 64'd0);
`endif
    rst = 1'b0;
    issue(16'h0A24, 32'd210);
    expect_issue(5'd1, 3'd2, 16'h0005, 16'h0005, 16'h0000, 32'd210);

    // Load-use on rs1
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 3'd1;
    bus.in_valid = 1'b1; bus.in_word = 16'h0A24; bus.in_pc = 32'd300;
    @(negedge clk);
    check("hazard_rs1_in_ready", {63'd0, bus.in_ready}, 64'd0);
    to_drive();
    check("hazard_rs1_bubble", {63'd0, bus.out_valid}, 64'd0);
    ex_valid = 1'b0; ex_mem_read = 1'b0;
    issue(16'h0A24, 32'd300);
    expect_issue(5'd1, 3'd2, 16'h0005, 16'h0005, 16'h0000, 32'd300);

    // Matching non-load in EX is not a hazard
    ex_valid = 1'b1; ex_mem_read = 1'b0; ex_rd = 3'd1;
    issue(16'h0A24, 32'd310);
    expect_issue(5'd1, 3'd2, 16'h0005, 16'h0005, 16'h0000, 32'd310);
    ex_valid = 1'b0;

    // Load-use on rs2 of a held first word while waiting for the immediate
    issue(16'h276A, 32'd320);
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 3'd2;
    bus.in_valid = 1'b1; bus.in_word = 16'hBEEF; bus.in_pc = 32'd322;
    @(negedge clk);
    check("hazard_imm_in_ready", {63'd0, bus.in_ready}, 64'd0);
    to_drive();
    ex_valid = 1'b0; ex_mem_read = 1'b0;
    issue(16'hBEEF, 32'd322);
    expect_issue(5'd4, 3'd7, 16'h0033, 16'h0022, 16'hBEEF, 32'd320);

    // Stall holds the issued bundle and blocks fetch
    issue(16'h1D4C, 32'd400);
    expect_issue(5'd3, 3'd5, 16'h0022, 16'h0033, 16'h0000, 32'd400);
    stall = 1'b1;
    bus.in_valid = 1'b1; bus.in_word = 16'h0A24; bus.in_pc = 32'd410;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
      check("stall_valid",    {63'd0, bus.out_valid}, 64'd1);
      check("stall_opc",      {59'd0, bus.out_opc},  64'd3);
      check("stall_a",        {48'd0, bus.out_a},    64'h22);
      check("stall_b",        {48'd0, bus.out_b},    64'h33);
      check("stall_pc",       {32'd0, bus.out_pc},   64'd400);
      to_drive();
    end
    stall = 1'b0;
    issue(16'h0A24, 32'd410);
    expect_issue(5'd1, 3'd2, 16'h0005, 16'h0005, 16'h0000, 32'd410);

    // Flush with stall while in S_IMM drops the held word
    issue(16'h0A26, 32'd500);
    flush = 1'b1; stall = 1'b1;
    bus.in_valid = 1'b1; bus.in_word = 16'h1D4C; bus.in_pc = 32'd502;
    @(negedge clk);
    check("flush_in_ready", {63'd0, bus.in_ready}, 64'd0);
    to_drive();
    flush = 1'b0; stall = 1'b0; bus.in_valid = 1'b0;
    check("flush_valid", {63'd0, bus.out_valid}, 64'd0);
    issue(16'h1D4C, 32'd510);
    expect_issue(5'd3, 3'd5, 16'h0022, 16'h0033, 16'h0000, 32'd510);

    repeat (3) to_drive();
`ifdef DECODE_BUBBLE_STATS_EN
    check("bubble_cnt_two", {48'd0, bubble_cnt}, 64'd2);
`endif
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
